// File: rtl/prio_pkg.sv
// Shared types and helpers for the priority grant decoder.
// Code points, grant vector, FSM state encoding and counter sizing.
package prio_pkg;

  localparam logic [2:0] CODE_NONE = 3'd0;
  localparam logic [2:0] CODE_MAX  = 3'd4;

  typedef logic [2:0] prio_code_t;
  typedef logic [3:0] grant_t;

  typedef enum logic [1:0] {IDLE, HOLD, GAP} grant_state_t;

  function automatic grant_t code_to_grant(prio_code_t c);
    case (c)
      3'd1:    return 4'b0001;
      3'd2:    return 4'b0010;
      3'd3:    return 4'b0100;
      3'd4:    return 4'b1000;
      default: return 4'b0000;
    endcase
  endfunction

  // Down-counter must hold the larger of the two phase lengths; never narrower than 1 bit.
  function automatic int cnt_width(int h, int g);
    int m;
    m = (h > g) ? h : g;
    return ($clog2(m + 1) < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/hold_timer.sv
// Loadable down-counter with zero flag, shared by the HOLD and GAP phases.
// Latency: load takes effect on the next edge; no backpressure (free-running to zero).
module hold_timer #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/prio_grant_decoder.sv
// Decodes a priority code to a one-hot grant held HOLD_CYCLES, then idles GAP_CYCLES.
// Latency: grant visible the cycle after the accepting edge; ready low through HOLD and GAP.
// Optional PRIO_GRANT_CNT_EN adds a saturating count of legal transfers on grant_cnt.
module prio_grant_decoder
  import prio_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  code,
  input  logic        valid,
  output logic        ready,
  output logic [3:0]  grant,
  output logic        busy,
  output logic        err,
  input  logic        err_clr
`ifdef PRIO_GRANT_CNT_EN
  ,
  output logic [15:0] grant_cnt
`endif
);

  localparam int             CW        = cnt_width(HOLD_CYCLES, GAP_CYCLES);
  localparam bit             HAS_GAP   = (GAP_CYCLES > 0);
  localparam logic [CW-1:0]  HOLD_LOAD = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0]  GAP_LOAD  = CW'(HAS_GAP ? GAP_CYCLES - 1 : 0);

  grant_state_t  state;
  logic          accept;
  logic          legal;
  logic          err_set;
  logic          tmr_load;
  logic [CW-1:0] tmr_val;
  logic          tmr_zero;

  assign ready   = (state == IDLE);
  assign accept  = valid && ready;
  assign legal   = (prio_code_t'(code) != CODE_NONE) && (prio_code_t'(code) <= CODE_MAX);
  assign err_set = accept && (prio_code_t'(code) > CODE_MAX);

  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = HOLD_LOAD;
    case (state)
      IDLE: tmr_load = accept && legal;
      HOLD: begin
        if (tmr_zero && HAS_GAP) begin
          tmr_load = 1'b1;
          tmr_val  = GAP_LOAD;
        end
      end
      default: ;
    endcase
  end

  hold_timer #(.W(CW)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      grant <= '0;
      busy  <= 1'b0;
      err   <= 1'b0;
    end else begin
      // A new illegal transfer beats a simultaneous clear.
      err <= err_set || (err && !err_clr);
      case (state)
        IDLE: begin
          if (accept && legal) begin
            state <= HOLD;
            grant <= code_to_grant(prio_code_t'(code));
            busy  <= 1'b1;
          end
        end
        HOLD: begin
          if (tmr_zero) begin
            grant <= '0;
            if (HAS_GAP) begin
              state <= GAP;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        GAP: begin
          if (tmr_zero) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          grant <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef PRIO_GRANT_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant_cnt <= '0;
    end else if (accept && legal && (grant_cnt != 16'hFFFF)) begin
      grant_cnt <= grant_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_prio_grant_decoder.sv
// Bench for prio_grant_decoder: DUT 0 uses HOLD=4/GAP=1, DUT 1 uses HOLD=4/GAP=0.
// Expected outputs come from a timeline model (grant window and ready time per accept).
module tb_prio_grant_decoder;

  localparam int H = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  code_i   [2];
  logic        valid_i  [2];
  logic        err_clr_i[2];
  logic        ready_o  [2];
  logic [3:0]  grant_o  [2];
  logic        busy_o   [2];
  logic        err_o    [2];
  logic [15:0] gcnt_o   [2];

  int checks = 0;
  int passes = 0;
  int cyc    = 0;

  // Model: accept on edge n gives grant visible after edges n..n+H-1, ready again after edge n+H+G.
  int         g_from  [2];
  int         g_to    [2];
  int         ready_at[2];
  logic [3:0] g_val   [2];
  logic       m_err   [2];
  int         m_cnt   [2];

  always #5 clk = ~clk;

  prio_grant_decoder #(.HOLD_CYCLES(H), .GAP_CYCLES(1)) dut0 (
    .clk(clk), .reset(reset), .code(code_i[0]), .valid(valid_i[0]), .ready(ready_o[0]),
    .grant(grant_o[0]), .busy(busy_o[0]), .err(err_o[0]), .err_clr(err_clr_i[0])
`ifdef PRIO_GRANT_CNT_EN
    , .grant_cnt(gcnt_o[0])
`endif
  );

  prio_grant_decoder #(.HOLD_CYCLES(H), .GAP_CYCLES(0)) dut1 (
    .clk(clk), .reset(reset), .code(code_i[1]), .valid(valid_i[1]), .ready(ready_o[1]),
    .grant(grant_o[1]), .busy(busy_o[1]), .err(err_o[1]), .err_clr(err_clr_i[1])
`ifdef PRIO_GRANT_CNT_EN
    , .grant_cnt(gcnt_o[1])
`endif
  );

`ifndef PRIO_GRANT_CNT_EN
  initial begin
    gcnt_o[0] = '0;
    gcnt_o[1] = '0;
  end
`endif

  function automatic int gap_of(int d);
    return (d == 0) ? 1 : 0;
  endfunction

  function automatic logic m_ready(int d);
    return cyc >= ready_at[d];
  endfunction

  function automatic logic [3:0] m_grant(int d);
    return (cyc >= g_from[d] && cyc <= g_to[d]) ? g_val[d] : 4'b0000;
  endfunction

  task automatic m_reset();
    for (int d = 0; d < 2; d++) begin
      g_from[d]   = 1;
      g_to[d]     = 0;
      ready_at[d] = 0;
      g_val[d]    = 4'b0000;
      m_err[d]    = 1'b0;
      m_cnt[d]    = 0;
    end
  endtask

  // Advance one clock, updating the model from the inputs presented before the edge.
  task automatic tick();
    logic acc;
    logic set;
    for (int d = 0; d < 2; d++) begin
      acc = !reset && valid_i[d] && m_ready(d);
      set = acc && (code_i[d] > 3'd4);
      if (acc && code_i[d] >= 3'd1 && code_i[d] <= 3'd4) begin
        g_from[d]   = cyc + 1;
        g_to[d]     = cyc + H;
        g_val[d]    = 4'b0001 << (code_i[d] - 3'd1);
        ready_at[d] = cyc + 1 + H + gap_of(d);
        if (m_cnt[d] < 65535) m_cnt[d]++;
      end
      if (!reset) m_err[d] = set || (m_err[d] && !err_clr_i[d]);
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic test_reset();
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++; if (ready_o[d] !== 1'b1) $display("FAIL reset_ready d%0d: got %b want 1", d, ready_o[d]); else passes++;
      checks++; if (grant_o[d] !== 4'b0000) $display("FAIL reset_grant d%0d: got %b want 0000", d, grant_o[d]); else passes++;
      checks++; if (busy_o[d] !== 1'b0) $display("FAIL reset_busy d%0d: got %b want 0", d, busy_o[d]); else passes++;
      checks++; if (err_o[d] !== 1'b0) $display("FAIL reset_err d%0d: got %b want 0", d, err_o[d]); else passes++;
`ifdef PRIO_GRANT_CNT_EN
      checks++; if (gcnt_o[d] !== 16'd0) $display("FAIL reset_cnt d%0d: got %0d want 0", d, gcnt_o[d]); else passes++;
`endif
    end
    tick();
    tick();
    reset = 1'b0;
    tick();
    checks++; if (ready_o[0] !== 1'b1) $display("FAIL post_reset_ready: got %b want 1", ready_o[0]); else passes++;
  endtask

  task automatic test_single();
    int hi;
    int first_ready;
    hi = 0;
    first_ready = -1;
    code_i[0]  = 3'd3;
    valid_i[0] = 1'b1;
    tick();
    valid_i[0] = 1'b0;
    for (int s = 0; s < 8; s++) begin
      checks++; if (grant_o[0] !== m_grant(0)) $display("FAIL single_grant s%0d: got %b want %b", s, grant_o[0], m_grant(0)); else passes++;
      checks++; if (ready_o[0] !== m_ready(0)) $display("FAIL single_ready s%0d: got %b want %b", s, ready_o[0], m_ready(0)); else passes++;
      checks++; if (busy_o[0] !== !m_ready(0)) $display("FAIL single_busy s%0d: got %b want %b", s, busy_o[0], !m_ready(0)); else passes++;
      if (grant_o[0] === 4'b0100) hi++;
      if (ready_o[0] === 1'b1 && first_ready < 0) first_ready = s;
      tick();
    end
    checks++; if (hi !== 4) $display("FAIL single_hold_len: got %0d want 4", hi); else passes++;
    checks++; if (first_ready !== 5) $display("FAIL single_ready_return: got %0d want 5", first_ready); else passes++;
  endtask

  task automatic test_back_to_back();
    logic [2:0] seq[2];
    logic       acc;
    int         n1, n4, waited;
    seq[0] = 3'd1;
    seq[1] = 3'd4;
    n1 = 0;
    n4 = 0;
    valid_i[0] = 1'b1;
    for (int k = 0; k < 2; k++) begin
      code_i[0] = seq[k];
      waited = 0;
      do begin
        acc = m_ready(0);
        checks++; if (ready_o[0] !== acc) $display("FAIL b2b_ready cyc%0d: got %b want %b", cyc, ready_o[0], acc); else passes++;
        tick();
        waited++;
        checks++; if (grant_o[0] !== m_grant(0)) $display("FAIL b2b_grant cyc%0d: got %b want %b", cyc, grant_o[0], m_grant(0)); else passes++;
        if (grant_o[0] === 4'b0001) n1++;
        if (grant_o[0] === 4'b1000) n4++;
      end while (!acc && waited < 20);
      if (!acc) begin
        checks++;
        $display("FAIL b2b_timeout: got no accept in %0d cycles want accept", waited);
      end
    end
    valid_i[0] = 1'b0;
    for (int s = 0; s < 7; s++) begin
      tick();
      checks++; if (grant_o[0] !== m_grant(0)) $display("FAIL b2b_tail cyc%0d: got %b want %b", cyc, grant_o[0], m_grant(0)); else passes++;
      checks++; if ($countones(grant_o[0]) > 1) $display("FAIL b2b_onehot cyc%0d: got %b want <=1 bit", cyc, grant_o[0]); else passes++;
      if (grant_o[0] === 4'b1000) n4++;
    end
    checks++; if (n1 !== 4) $display("FAIL b2b_len1: got %0d want 4", n1); else passes++;
    checks++; if (n4 !== 4) $display("FAIL b2b_len4: got %0d want 4", n4); else passes++;
  endtask

  task automatic test_zero_code();
    code_i[0]  = 3'd0;
    valid_i[0] = 1'b1;
    for (int s = 0; s < 3; s++) begin
      tick();
      checks++; if (grant_o[0] !== 4'b0000) $display("FAIL zero_grant s%0d: got %b want 0000", s, grant_o[0]); else passes++;
      checks++; if (ready_o[0] !== 1'b1) $display("FAIL zero_ready s%0d: got %b want 1", s, ready_o[0]); else passes++;
      checks++; if (err_o[0] !== 1'b0) $display("FAIL zero_err s%0d: got %b want 0", s, err_o[0]); else passes++;
    end
    valid_i[0] = 1'b0;
`ifdef PRIO_GRANT_CNT_EN
    checks++; if (gcnt_o[0] !== 16'(m_cnt[0])) $display("FAIL zero_cnt: got %0d want %0d", gcnt_o[0], m_cnt[0]); else passes++;
`endif
  endtask

  task automatic test_illegal();
    code_i[0]  = 3'd6;
    valid_i[0] = 1'b1;
    tick();
    valid_i[0] = 1'b0;
    checks++; if (err_o[0] !== 1'b1) $display("FAIL illegal_set: got %b want 1", err_o[0]); else passes++;
    checks++; if (grant_o[0] !== 4'b0000) $display("FAIL illegal_grant: got %b want 0000", grant_o[0]); else passes++;
    tick();
    tick();
    checks++; if (err_o[0] !== 1'b1) $display("FAIL illegal_sticky: got %b want 1", err_o[0]); else passes++;
    code_i[0]    = 3'd7;
    valid_i[0]   = 1'b1;
    err_clr_i[0] = 1'b1;
    tick();
    valid_i[0] = 1'b0;
    checks++; if (err_o[0] !== 1'b1) $display("FAIL illegal_set_wins: got %b want 1", err_o[0]); else passes++;
    tick();
    err_clr_i[0] = 1'b0;
    checks++; if (err_o[0] !== 1'b0) $display("FAIL illegal_clear: got %b want 0", err_o[0]); else passes++;
    checks++; if (err_o[0] !== m_err[0]) $display("FAIL illegal_model: got %b want %b", err_o[0], m_err[0]); else passes++;
  endtask

  task automatic test_reset_mid_hold();
    code_i[0]  = 3'd2;
    valid_i[0] = 1'b1;
    tick();
    valid_i[0] = 1'b0;
    tick();
    checks++; if (grant_o[0] !== 4'b0010) $display("FAIL rst_hold_pre: got %b want 0010", grant_o[0]); else passes++;
    #2;
    reset = 1'b1;
    m_reset();
    #1;
    checks++; if (grant_o[0] !== 4'b0000) $display("FAIL rst_hold_grant: got %b want 0000", grant_o[0]); else passes++;
    checks++; if (busy_o[0] !== 1'b0) $display("FAIL rst_hold_busy: got %b want 0", busy_o[0]); else passes++;
    checks++; if (ready_o[0] !== 1'b1) $display("FAIL rst_hold_ready: got %b want 1", ready_o[0]); else passes++;
    tick();
    reset = 1'b0;
    for (int s = 0; s < 5; s++) begin
      tick();
      checks++; if (grant_o[0] !== 4'b0000) $display("FAIL rst_hold_residual s%0d: got %b want 0000", s, grant_o[0]); else passes++;
      checks++; if (ready_o[0] !== 1'b1) $display("FAIL rst_hold_ready_after s%0d: got %b want 1", s, ready_o[0]); else passes++;
    end
  endtask

  task automatic test_gap0_cnt();
    logic [2:0] seq[8];
    logic       acc;
    int         hi, waited, cnt0;
    seq = '{3'd1, 3'd0, 3'd2, 3'd6, 3'd3, 3'd0, 3'd4, 3'd2};
    hi = 0;
    cnt0 = m_cnt[1];
    valid_i[1] = 1'b1;
    for (int k = 0; k < 8; k++) begin
      code_i[1] = seq[k];
      waited = 0;
      do begin
        acc = m_ready(1);
        tick();
        waited++;
        checks++; if (grant_o[1] !== m_grant(1)) $display("FAIL gap0_grant cyc%0d: got %b want %b", cyc, grant_o[1], m_grant(1)); else passes++;
        checks++; if (ready_o[1] !== m_ready(1)) $display("FAIL gap0_ready cyc%0d: got %b want %b", cyc, ready_o[1], m_ready(1)); else passes++;
        if (grant_o[1] !== 4'b0000) hi++;
      end while (!acc && waited < 20);
      if (!acc) begin
        checks++;
        $display("FAIL gap0_timeout k%0d: got no accept want accept", k);
      end
    end
    valid_i[1] = 1'b0;
    for (int s = 0; s < 6; s++) begin
      tick();
      if (grant_o[1] !== 4'b0000) hi++;
    end
    checks++; if (hi !== 20) $display("FAIL gap0_grant_cycles: got %0d want 20", hi); else passes++;
    checks++; if (err_o[1] !== 1'b1) $display("FAIL gap0_err: got %b want 1", err_o[1]); else passes++;
`ifdef PRIO_GRANT_CNT_EN
    checks++; if (gcnt_o[1] !== 16'(cnt0 + 5)) $display("FAIL gap0_cnt: got %0d want %0d", gcnt_o[1], cnt0 + 5); else passes++;
`endif
  endtask

  task automatic test_random();
    for (int s = 0; s < 400; s++) begin
      for (int d = 0; d < 2; d++) begin
        valid_i[d]   = ($urandom_range(0, 1) == 1);
        code_i[d]    = 3'($urandom_range(0, 7));
        err_clr_i[d] = ($urandom_range(0, 7) == 0);
      end
      tick();
      for (int d = 0; d < 2; d++) begin
        checks++; if (grant_o[d] !== m_grant(d)) $display("FAIL rand_grant d%0d cyc%0d: got %b want %b", d, cyc, grant_o[d], m_grant(d)); else passes++;
        checks++; if (ready_o[d] !== m_ready(d)) $display("FAIL rand_ready d%0d cyc%0d: got %b want %b", d, cyc, ready_o[d], m_ready(d)); else passes++;
        checks++; if (busy_o[d] !== !m_ready(d)) $display("FAIL rand_busy d%0d cyc%0d: got %b want %b", d, cyc, busy_o[d], !m_ready(d)); else passes++;
        checks++; if (err_o[d] !== m_err[d]) $display("FAIL rand_err d%0d cyc%0d: got %b want %b", d, cyc, err_o[d], m_err[d]); else passes++;
`ifdef PRIO_GRANT_CNT_EN
        checks++; if (gcnt_o[d] !== 16'(m_cnt[d])) $display("FAIL rand_cnt d%0d cyc%0d: got %0d want %0d", d, cyc, gcnt_o[d], m_cnt[d]); else passes++;
`endif
      end
    end
    for (int d = 0; d < 2; d++) begin
      valid_i[d]   = 1'b0;
      err_clr_i[d] = 1'b0;
    end
  endtask

  initial begin
    reset = 1'b1;
    for (int d = 0; d < 2; d++) begin
      code_i[d]    = 3'd0;
      valid_i[d]   = 1'b0;
      err_clr_i[d] = 1'b0;
    end
    m_reset();
    test_reset();
    test_single();
    test_back_to_back();
    test_zero_code();
    test_illegal();
    test_reset_mid_hold();
    test_gap0_cnt();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
